// File: rtl/cache_wb_top.sv
// rtl/cache_wb_top.sv - direct-mapped write-back, write-allocate cache with embedded DRAM model
module cache_wb_top #(
  parameter int INDEX_COUNT  = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DRAM_DEPTH   = 1024,
  parameter int DRAM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  mem_enable,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);

  localparam int IDX_W = $clog2(INDEX_COUNT);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int TAG_W = WA_W - IDX_W;
  localparam int DA_W  = $clog2(DRAM_DEPTH);
  localparam int CNT_W = (DRAM_LATENCY > 1) ? $clog2(DRAM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   replay;
  logic [IDX_W-1:0]       cap_index;
  logic [TAG_W-1:0]       cap_tag;
  logic [TAG_W-1:0]       victim_tag;

  logic [INDEX_COUNT-1:0] line_valid;
  logic [INDEX_COUNT-1:0] line_dirty;
  logic [TAG_W-1:0]       line_tag  [INDEX_COUNT];
  logic [DATA_WIDTH-1:0]  line_data [INDEX_COUNT];

  // Backing store starts all-zero and is deliberately outside the reset domain.
  logic [DATA_WIDTH-1:0]  dram [DRAM_DEPTH] = '{default: '0};

  logic [IDX_W-1:0]       req_index;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic                   victim_dirty;
  logic                   last_cycle;
  logic [WA_W-1:0]        refill_wa;
  logic [WA_W-1:0]        wb_wa;
  logic                   unused_bits;

  assign req_index    = address[IDX_W+1:2];
  assign req_tag      = address[ADDR_WIDTH-1:IDX_W+2];
  assign hit          = mem_enable & line_valid[req_index] & (line_tag[req_index] == req_tag);
  assign victim_dirty = line_valid[req_index] & line_dirty[req_index];
  assign last_cycle   = (cnt == CNT_LAST);
  // DRAM traffic always uses the index/tags captured at the miss, never the live inputs.
  assign refill_wa    = {cap_tag, cap_index};
  assign wb_wa        = {victim_tag, cap_index};
  // Byte-offset bits and word-address bits above the DRAM depth are don't-cares.
  assign unused_bits  = ^{address[1:0], refill_wa, wb_wa};

  // Stall: outstanding miss in IDLE, always while a DRAM transfer runs; never during reset.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      if (state == IDLE) stall = mem_enable & ~hit;
      else               stall = 1'b1;
    end
  end

  // Control FSM: line state bits, counters, captured miss context and registered load data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      replay     <= 1'b0;
      cap_index  <= '0;
      cap_tag    <= '0;
      victim_tag <= '0;
      line_valid <= '0;
      line_dirty <= '0;
      read_data  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          replay <= 1'b0;
          if (hit) begin
            if (write_en) line_dirty[req_index] <= 1'b1;
            else          read_data <= line_data[req_index];
            // The replay after a refill was already counted as a miss.
            if (!replay) hit_count <= hit_count + 32'd1;
          end else if (mem_enable) begin
            cap_index  <= req_index;
            cap_tag    <= req_tag;
            victim_tag <= line_tag[req_index];
            cnt        <= '0;
            miss_count <= miss_count + 32'd1;
            if (victim_dirty) begin
              state    <= WRITEBACK;
              wb_count <= wb_count + 32'd1;
            end else begin
              state    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (last_cycle) begin
            cnt   <= '0;
            state <= REFILL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REFILL: begin
          if (last_cycle) begin
            line_valid[cap_index] <= 1'b1;
            line_dirty[cap_index] <= 1'b0;
            replay                <= 1'b1;
            cnt                   <= '0;
            state                 <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Line payload: store-hit merge and refill install; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == IDLE && hit && write_en) begin
        line_data[req_index] <= write_data;
      end else if (state == REFILL && last_cycle) begin
        line_data[cap_index] <= dram[refill_wa[DA_W-1:0]];
        line_tag[cap_index]  <= cap_tag;
      end
    end
  end

  // Victim commit happens only on the final writeback cycle so a reset mid-transfer leaves DRAM intact.
  always_ff @(posedge clk) begin
    if (rst && state == WRITEBACK && last_cycle) begin
      dram[wb_wa[DA_W-1:0]] <= line_data[cap_index];
    end
  end

endmodule

// File: doc/cache_wb_top.md
CACHE_WB_TOP -- requirements
Module: cache_wb_top

Interface
REQ-001 SHALL provide parameter INDEX_COUNT, default 16, meaning number of direct-mapped lines; power of 2, at least 2.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, meaning line/word width in bits.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-004 SHALL provide parameter DRAM_DEPTH, default 1024, meaning words in the internal DRAM model; power of 2.
REQ-005 SHALL provide parameter DRAM_LATENCY, default 4, meaning cycles per DRAM read or write; at least 1.
REQ-006 SHALL have one clock; reset is synchronous and active-low.
REQ-007 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-009 SHALL have port address, input, ADDR_WIDTH bits: byte address; bits [1:0] ignored.
REQ-010 SHALL have port mem_enable, input, 1 bit: request valid.
REQ-011 SHALL have port write_en, input, 1 bit: 1 = store, 0 = load.
REQ-012 SHALL have port write_data, input, DATA_WIDTH bits: store data.
REQ-013 SHALL have port stall, output, 1 bit: request not yet completed; requester holds inputs stable.
REQ-014 SHALL have port read_data, output, DATA_WIDTH bits: registered load result.
REQ-015 SHALL have ports hit_count, miss_count and wb_count, each output, 32 bits: event counters that wrap modulo 2^32.

Function
REQ-016 SHALL decode word address as address>>2, index = low log2(INDEX_COUNT) bits of that, tag = remaining upper bits; per line store valid, dirty, tag, data.
REQ-017 SHALL embed a DRAM model indexed by (address>>2) mod DRAM_DEPTH, all words zero at time 0, unaffected by rst.
REQ-018 SHALL implement FSM states IDLE, WRITEBACK, REFILL, each DRAM state lasting exactly DRAM_LATENCY cycles, timed by an internal counter.
REQ-019 In IDLE, hit = mem_enable & valid[index] & tag match; stall SHALL be combinational: mem_enable & ~hit in IDLE, 1 in WRITEBACK/REFILL.
REQ-020 Load hit: read_data SHALL take line data at the next edge; stall 0; read_data otherwise holds its last value.
REQ-021 Store hit: line data SHALL take write_data and dirty SHALL be set at the next edge; read_data unchanged.
REQ-022 Miss with victim valid & dirty: SHALL go IDLE->WRITEBACK; the victim word is committed to DRAM at the victim's address only on the final WRITEBACK cycle; then ->REFILL.
REQ-023 Miss with victim clean or invalid: SHALL go IDLE->REFILL directly.
REQ-024 On the final REFILL cycle SHALL install the DRAM word, set valid=1 and the new tag, clear dirty, then ->IDLE, where the held request replays as a hit and completes per REQ-020/021.
REQ-025 Write-allocate: a store miss SHALL refill and then merge via the replay; DRAM is not updated until eviction.
REQ-026 Miss latency from the request cycle to the completing edge: clean = DRAM_LATENCY+2 cycles, dirty = 2*DRAM_LATENCY+2; stall is high DRAM_LATENCY+1 or 2*DRAM_LATENCY+1 cycles respectively.
REQ-027 miss_count SHALL increment once per miss on leaving IDLE; wb_count SHALL increment on entering WRITEBACK; hit_count SHALL increment on IDLE hits excluding the replay after a refill (internal replay flag).
REQ-028 mem_enable deasserted or inputs changed while stall=1 is a protocol violation; the transfer completes using the captured index/tag, and the replay is dropped if mem_enable=0.
REQ-029 mem_enable=0 in IDLE SHALL cause no state, line or counter change.

Reset
REQ-030 rst=0 at an edge SHALL force IDLE, clear all valid and dirty bits, counters=0, read_data=0, DRAM counter=0 and replay flag=0; stall=0 while rst is low and on the cycle after.
REQ-031 Reset during WRITEBACK SHALL abort without modifying DRAM; reset during REFILL SHALL install nothing.

Verification (INDEX_COUNT=16, DATA_WIDTH=32, DRAM_LATENCY=4)
REQ-032 After reset, load 0x10 -> stall high 5 cycles, read_data=0 on the 6th edge, miss_count=1, hit_count=0.
REQ-033 Then store 0xDEADBEEF to 0x10, then load 0x10 -> stall never high, read_data=0xDEADBEEF the next edge, hit_count=2.
REQ-034 Then load 0x50 (index 4, conflicts with 0x10) -> stall high 9 cycles, wb_count=1, read_data=0; then load 0x10 -> stall 5 cycles, read_data=0xDEADBEEF (proves writeback).
REQ-035 After reset, store 0xA5A5A5A5 to 0x20 -> stall 5 cycles, line dirty, DRAM word 8 remains 0; load 0x60 -> writeback, after which DRAM word 8=0xA5A5A5A5.
REQ-036 Dirty miss, assert rst low in the 2nd WRITEBACK cycle -> stall 0 the next cycle, all counters 0, DRAM victim word unchanged, a subsequent load of the old address misses.
